// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised IEEE 1149.1-style TAP controller.
// Holds the 16-state controller, an IR_WIDTH instruction register, the BYPASS
// register and instruction decode, and steers NUM_DR external scan chains via
// one-hot selects plus shared capture/shift/update strobes.
// Optional feature macro: TAP_IDCODE_EN adds a 32-bit IDCODE register and makes
// IDCODE_OP the reset instruction; without it the reset instruction is BYPASS.
// Handshake note: there is no valid/ready traffic here; every input is sampled
// on each rising i_tck edge and i_trst (synchronous, active high) wins over all.
// IR_WIDTH must be in the range 2..32 (the decode zero-extends to 32 bits).
module jtag_tap_param #(
   parameter int              IR_WIDTH   = 4,
   parameter int              NUM_DR     = 3,
   parameter logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(4'b1110),
   parameter logic [31:0]     IDCODE_VAL = 32'h1000_0CAF
) (
   input  logic                i_tck,
   input  logic                i_trst,
   input  logic                i_tms,
   input  logic                i_tdi,
   output logic                o_tdo,
   output logic                o_tdo_en,
   input  logic [NUM_DR-1:0]   i_dr_tdo,
   output logic [NUM_DR-1:0]   o_dr_sel,
   output logic                o_capture_dr,
   output logic                o_shift_dr,
   output logic                o_update_dr,
   output logic [IR_WIDTH-1:0] o_ir_out,
   output logic [3:0]          o_tap_state
);

   typedef enum logic [3:0] {
      S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR,
      S_UPD_DR, S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
   } tap_state_t;

`ifdef TAP_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] IR_RST = IDCODE_OP;
`else
   localparam logic [IR_WIDTH-1:0] IR_RST = '1;
`endif

   // Configuration sanity: IR needs room for the 2-bit capture pattern, an
   // IDCODE must have bit0 set, and an all-ones IDCODE_OP would be shadowed by BYPASS.
   generate
      if (IR_WIDTH < 2 || IR_WIDTH > 32 || IDCODE_VAL[0] != 1'b1 || IDCODE_OP == '1) begin : g_bad_cfg
         $error("jtag_tap_param: illegal parameter combination");
      end
   endgenerate

   tap_state_t          r_state;
   tap_state_t          w_next;
   logic                r_capture_dr;
   logic                r_shift_dr;
   logic                r_update_dr;
   logic                r_tdo_en;
   logic [IR_WIDTH-1:0] r_ir_sh;
   logic [IR_WIDTH-1:0] r_ir_out;
   logic                r_bypass;
   logic [31:0]         w_ir_ext;
   logic                w_is_ones;
   logic                w_is_idcode;
   logic                w_chain_ok;
   logic [NUM_DR-1:0]   w_dr_sel;
   logic                w_tdo;

   // Standard 1149.1 TMS transition table
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_TLR:    w_next = i_tms ? S_TLR    : S_RTI;
         S_RTI:    w_next = i_tms ? S_SEL_DR : S_RTI;
         S_SEL_DR: w_next = i_tms ? S_SEL_IR : S_CAP_DR;
         S_CAP_DR: w_next = i_tms ? S_EX1_DR : S_SH_DR;
         S_SH_DR:  w_next = i_tms ? S_EX1_DR : S_SH_DR;
         S_EX1_DR: w_next = i_tms ? S_UPD_DR : S_PAU_DR;
         S_PAU_DR: w_next = i_tms ? S_EX2_DR : S_PAU_DR;
         S_EX2_DR: w_next = i_tms ? S_UPD_DR : S_SH_DR;
         S_UPD_DR: w_next = i_tms ? S_SEL_DR : S_RTI;
         S_SEL_IR: w_next = i_tms ? S_TLR    : S_CAP_IR;
         S_CAP_IR: w_next = i_tms ? S_EX1_IR : S_SH_IR;
         S_SH_IR:  w_next = i_tms ? S_EX1_IR : S_SH_IR;
         S_EX1_IR: w_next = i_tms ? S_UPD_IR : S_PAU_IR;
         S_PAU_IR: w_next = i_tms ? S_EX2_IR : S_PAU_IR;
         S_EX2_IR: w_next = i_tms ? S_UPD_IR : S_SH_IR;
         S_UPD_IR: w_next = i_tms ? S_SEL_DR : S_RTI;
         default:  w_next = S_TLR;
      endcase
   end

   // Controller state plus strobes registered from the next state, so each
   // strobe is high exactly while the controller sits in its state
   always_ff @(posedge i_tck) begin
      if (i_trst) begin
         r_state      <= S_TLR;
         r_capture_dr <= 1'b0;
         r_shift_dr   <= 1'b0;
         r_update_dr  <= 1'b0;
         r_tdo_en     <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_capture_dr <= (w_next == S_CAP_DR);
         r_shift_dr   <= (w_next == S_SH_DR);
         r_update_dr  <= (w_next == S_UPD_DR);
         r_tdo_en     <= (w_next == S_SH_DR) || (w_next == S_SH_IR);
      end
   end

   // Instruction shift register and latched instruction
   always_ff @(posedge i_tck) begin
      if (i_trst) begin
         r_ir_sh  <= '0;
         r_ir_out <= IR_RST;
      end else begin
         case (r_state)
            S_TLR:    r_ir_out <= IR_RST;
            S_CAP_IR: r_ir_sh  <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
            S_SH_IR:  r_ir_sh  <= {i_tdi, r_ir_sh[IR_WIDTH-1:1]};
            S_UPD_IR: r_ir_out <= r_ir_sh;
            default:  ;
         endcase
      end
   end

   // One-bit BYPASS register: cleared on capture, loaded from TDI while shifting
   always_ff @(posedge i_tck) begin
      if (i_trst)                  r_bypass <= 1'b0;
      else if (r_state == S_CAP_DR) r_bypass <= 1'b0;
      else if (r_state == S_SH_DR)  r_bypass <= i_tdi;
   end

`ifdef TAP_IDCODE_EN
   logic [31:0] r_idcode;

   // IDCODE register: loads the device ID on capture, shifts right while shifting
   always_ff @(posedge i_tck) begin
      if (i_trst)                  r_idcode <= IDCODE_VAL;
      else if (r_state == S_CAP_DR) r_idcode <= IDCODE_VAL;
      else if (r_state == S_SH_DR)  r_idcode <= {i_tdi, r_idcode[31:1]};
   end
`endif

   // Instruction decode: all-ones BYPASS first, then IDCODE, then chain index
   always_comb begin
      w_ir_ext  = 32'(r_ir_out);
      w_is_ones = &r_ir_out;
`ifdef TAP_IDCODE_EN
      w_is_idcode = !w_is_ones && (r_ir_out == IDCODE_OP);
`else
      w_is_idcode = 1'b0;
`endif
      w_chain_ok = !w_is_ones && !w_is_idcode && (w_ir_ext < 32'(NUM_DR));
      w_dr_sel   = '0;
      for (int k = 0; k < NUM_DR; k++) begin
         w_dr_sel[k] = w_chain_ok && (w_ir_ext == 32'(k));
      end
   end

   // TDO source mux; driven low outside the two shift states
   always_comb begin
      w_tdo = 1'b0;
      if (r_state == S_SH_IR) begin
         w_tdo = r_ir_sh[0];
      end else if (r_state == S_SH_DR) begin
`ifdef TAP_IDCODE_EN
         if (w_is_idcode)     w_tdo = r_idcode[0];
         else if (w_chain_ok) w_tdo = |(w_dr_sel & i_dr_tdo);
         else                 w_tdo = r_bypass;
`else
         if (w_chain_ok) w_tdo = |(w_dr_sel & i_dr_tdo);
         else            w_tdo = r_bypass;
`endif
      end
   end

   assign o_tdo        = w_tdo;
   assign o_tdo_en     = r_tdo_en;
   assign o_dr_sel     = w_dr_sel;
   assign o_capture_dr = r_capture_dr;
   assign o_shift_dr   = r_shift_dr;
   assign o_update_dr  = r_update_dr;
   assign o_ir_out     = r_ir_out;
   assign o_tap_state  = r_state;

endmodule
